// File: rtl/io_mem_pkg.sv
// Shared definitions for the IO memory responder: register map, STATUS
// bit positions, default TX FIFO depth and a small saturation helper.
package io_mem_pkg;

    // Default number of entries in the outbound TX FIFO (power of two).
    localparam int TX_DEPTH_DEFAULT = 8;

    // Word offsets, i.e. io_addr[7:2].
    localparam logic [5:0] OFF_STATUS  = 6'h00;
    localparam logic [5:0] OFF_RX_DATA = 6'h01;
    localparam logic [5:0] OFF_TX_DATA = 6'h02;
    localparam logic [5:0] OFF_CYCLE   = 6'h03;

    // STATUS register layout.
    localparam int STAT_TX_NOT_FULL = 0;
    localparam int STAT_RX_FULL     = 1;
    localparam int STAT_TX_OVERFLOW = 2;
    localparam int STAT_COUNT_LSB   = 4;

    // Clamp an occupancy value into the 4-bit STATUS count field.
    function automatic logic [3:0] satNibble(input logic [31:0] value);
        return (value > 32'd15) ? 4'd15 : value[3:0];
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Outbound byte FIFO. A push is accepted only when the FIFO is not full
// before the edge, so a pop in the same cycle never makes room for it.
module io_tx_fifo
    import io_mem_pkg::*;
#(
    parameter int DEPTH = TX_DEPTH_DEFAULT,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] headData
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CW'(DEPTH));
    assign doPush   = push && !full;
    assign doPop    = pop && (count != '0);
    assign headData = mem[rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/io_mem_responder.sv
// CPU-facing IO register block: STATUS, RX_DATA, TX_DATA and CYCLE word
// registers bridging memory-mapped loads/stores to byte streams.
module io_mem_responder
    import io_mem_pkg::*;
#(
    parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_we,
    input  logic [31:0] io_wdata,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [5:0]    wordOff;
    logic          anyWe;
    logic          selStatus;
    logic          selRx;
    logic          selTx;
    logic          selCycle;
    logic          pushReq;
    logic          txFull;
    logic [CW-1:0] txCount;
    logic          txOverflow;
    logic          rxFull;
    logic [7:0]    rxByte;
    logic [31:0]   cycleCount;
    logic [31:0]   statusWord;
    logic [31:0]   readData;

    assign wordOff   = io_addr[7:2];
    assign anyWe     = |io_we;
    assign selStatus = (wordOff == OFF_STATUS);
    assign selRx     = (wordOff == OFF_RX_DATA);
    assign selTx     = (wordOff == OFF_TX_DATA);
    assign selCycle  = (wordOff == OFF_CYCLE);
    assign pushReq   = selTx && io_we[0];

    assign tx_valid  = (txCount != '0);
    assign rx_ready  = !rxFull;

    io_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8),
        .CW    (CW)
    ) txFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushReq),
        .pushData (io_wdata[7:0]),
        .pop      (tx_valid && tx_ready),
        .full     (txFull),
        .count    (txCount),
        .headData (tx_data)
    );

    // Sticky overflow flag: set by a dropped push, cleared by any STATUS write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txOverflow <= 1'b0;
        end else if (selStatus && anyWe) begin
            txOverflow <= 1'b0;
        end else if (pushReq && txFull) begin
            txOverflow <= 1'b1;
        end
    end

    // One-entry RX holding register; a load of RX_DATA frees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxFull <= 1'b0;
            rxByte <= '0;
        end else if (io_re && selRx && rxFull) begin
            rxFull <= 1'b0;
        end else if (rx_valid && !rxFull) begin
            rxFull <= 1'b1;
            rxByte <= rx_data;
        end
    end

    // Free-running cycle counter; a CYCLE write restarts it at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycleCount <= '0;
        end else if (selCycle && anyWe) begin
            cycleCount <= '0;
        end else begin
            cycleCount <= cycleCount + 32'd1;
        end
    end

    // Load data mux over pre-edge state.
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        statusWord = '0;
        readData   = '0;
        statusWord[STAT_TX_NOT_FULL]                = !txFull;
        statusWord[STAT_RX_FULL]                    = rxFull;
        statusWord[STAT_TX_OVERFLOW]                = txOverflow;
        statusWord[STAT_COUNT_LSB +: 4]             = satNibble(32'(txCount));
        case (wordOff)
            OFF_STATUS:  readData = statusWord;
            OFF_RX_DATA: readData = rxFull ? {24'b0, rxByte} : 32'b0;
            OFF_CYCLE:   readData = cycleCount;
            default:     readData = '0;
        endcase
    end

    // Registered load return; holds its value when no load is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rdata <= '0;
        end else if (io_re) begin
            io_rdata <= readData;
        end
    end

endmodule

// File: tb/tb_io_mem_responder.sv
// Directed self-checking bench for io_mem_responder.
module tb_io_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] io_addr;
    logic [3:0]  io_we;
    logic [31:0] io_wdata;
    logic        io_re;
    logic [31:0] io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;

    io_mem_responder #(.TX_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_we    (io_we),
        .io_wdata (io_wdata),
        .io_re    (io_re),
        .io_rdata (io_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Store for one cycle; inputs change just after a falling edge.
    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        io_addr  = a;
        io_wdata = d;
        io_we    = we;
        @(negedge clk);
        io_we    = 4'b0;
    endtask

    // Load for one cycle and return the registered data half a cycle later.
    task automatic doRead(input logic [31:0] a, output logic [31:0] d);
        io_addr = a;
        io_re   = 1'b1;
        @(negedge clk);
        d       = io_rdata;
        io_re   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", io_rdata, 32'h0); end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        io_addr = 32'h0C;
        io_re   = 1'b1;
        @(negedge clk);
        checks++;
        if (io_rdata !== 32'h0) begin errors++; $display("FAIL resume_cycle0: got %h want %h", io_rdata, 32'h0); end
        @(negedge clk);
        io_re = 1'b0;
        checks++;
        if (io_rdata !== 32'h1) begin errors++; $display("FAIL resume_cycle1: got %h want %h", io_rdata, 32'h1); end
    endtask

    task automatic test_tx_single();
        logic [31:0] d;
        doWrite(32'h08, 32'h0000_0041, 4'b0001);
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
            errors++; $display("FAIL tx_single_head: got %b/%h want 1/41", tx_valid, tx_data);
        end
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0011) begin errors++; $display("FAIL tx_single_status: got %h want %h", d, 32'h11); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_single_drain: got %b want 0", tx_valid); end
        doWrite(32'h08, 32'h0000_0055, 4'b1110);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_lane_mask: got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) doWrite(32'h08, 32'(i), 4'b0001);
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0084) begin errors++; $display("FAIL ovf_status: got %h want %h", d, 32'h84); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({tx_valid, tx_data} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(i));
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", tx_valid); end
        // Load and store to STATUS together: load sees the flag still set.
        io_addr  = 32'h00;
        io_wdata = 32'h0;
        io_we    = 4'hF;
        io_re    = 1'b1;
        @(negedge clk);
        io_we = 4'b0;
        io_re = 1'b0;
        checks++;
        if (io_rdata !== 32'h0000_0005) begin errors++; $display("FAIL simul_status: got %h want %h", io_rdata, 32'h5); end
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL ovf_cleared: got %h want %h", d, 32'h1); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) doWrite(32'h08, 32'(8'h10 + i), 4'b0001);
        tx_ready = 1'b1;
        doWrite(32'h08, 32'h0000_00AA, 4'b0001);
        tx_ready = 1'b0;
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0075) begin errors++; $display("FAIL full_pushpop_status: got %h want %h", d, 32'h75); end
        doWrite(32'h00, 32'h0, 4'b1000);
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0071) begin errors++; $display("FAIL full_ovf_clear: got %h want %h", d, 32'h71); end
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            checks++;
            if ({tx_valid, tx_data} !== {1'b1, 8'(8'h10 + i)}) begin
                errors++; $display("FAIL full_drain[%0d]: got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(8'h10 + i));
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_dropped: got %b/%h want empty", tx_valid, tx_data); end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        rx_data  = 8'h5C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_fall: got %b want 0", rx_ready); end
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0003) begin errors++; $display("FAIL rx_status: got %h want %h", d, 32'h3); end
        doRead(32'h04, d);
        checks++;
        if (d !== 32'h0000_005C) begin errors++; $display("FAIL rx_data: got %h want %h", d, 32'h5C); end
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_rise: got %b want 1", rx_ready); end
        doRead(32'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_read: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_cycle();
        logic [31:0] d;
        doWrite(32'h0C, 32'hDEAD_BEEF, 4'hF);
        repeat (3) @(negedge clk);
        doRead(32'h0C, d);
        checks++;
        if (d !== 32'h0000_0003) begin errors++; $display("FAIL cycle_after_write: got %h want %h", d, 32'h3); end
        force dut.cycleCount = 32'hFFFF_FFFF;
        release dut.cycleCount;
        doRead(32'h0C, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max: got %h want %h", d, 32'hFFFF_FFFF); end
        doRead(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL cycle_wrap: got %h want %h", d, 32'h0); end
        // Load and store to CYCLE together: pre-edge value returned, then restart.
        io_addr = 32'h0C;
        io_we   = 4'hF;
        io_re   = 1'b1;
        @(negedge clk);
        io_we = 4'b0;
        io_re = 1'b0;
        checks++;
        if (io_rdata !== 32'h1) begin errors++; $display("FAIL simul_cycle: got %h want %h", io_rdata, 32'h1); end
        doRead(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL cycle_restart: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        doWrite(32'h40, 32'hFFFF_FFFF, 4'hF);
        doRead(32'h40, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_40: got %h want %h", d, 32'h0); end
        doRead(32'hFC, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_FC: got %h want %h", d, 32'h0); end
        doRead(32'h100, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL alias_status: got %h want %h", d, 32'h1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) doWrite(32'h08, 32'(8'hA0 + i), 4'b0001);
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0043) begin errors++; $display("FAIL mid_status: got %h want %h", d, 32'h43); end
        tx_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL async_tx_valid: got %b want 0", tx_valid); end
        checks++;
        if (io_rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h want %h", io_rdata, 32'h0); end
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL async_rx_ready: got %b want 1", rx_ready); end
        @(negedge clk);
        rst      = 1'b1;
        tx_ready = 1'b0;
        doRead(32'h00, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL post_reset_status: got %h want %h", d, 32'h1); end
    endtask

    initial begin
        rst      = 1'b0;
        io_addr  = '0;
        io_we    = '0;
        io_wdata = '0;
        io_re    = 1'b0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        test_reset();
        test_tx_single();
        test_overflow();
        test_push_pop_full();
        test_rx();
        test_cycle();
        test_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
